// File: rtl/ts_frame_serializer.sv
// ts_frame_serializer: pops FIFO words and emits them as SOF / payload MSB-first / XOR checksum
// byte frames over a valid/ready link.
module ts_frame_serializer #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [7:0] SOF_BYTE   = 8'hA5,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o
);
    localparam int N = DATA_WIDTH / 8;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         idx;
    logic [7:0]            csum;
    logic                  accept;
    assign accept = tx_valid_o && tx_ready_i;
    assign tx_valid_o = state != IDLE;
    assign busy_o = state != IDLE;
    // a pop in CSUM is only legal on the accept that completes the frame
    assign fifo_pop_o = rst_ni && !flush_i && !fifo_empty_i &&
                        (state == IDLE || (state == CSUM && tx_ready_i));
    always_comb
        tx_data_o = state == HDR  ? SOF_BYTE :
                    state == DATA ? shreg[DATA_WIDTH-1 -: 8] :
                    state == CSUM ? csum : 8'h00;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            csum        <= '0;
            frame_cnt_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (fifo_pop_o) begin
                    shreg <= fifo_data_i;
                    csum  <= '0;
                    idx   <= '0;
                    state <= HDR;
                end
                HDR: if (accept) state <= DATA;
                DATA: if (accept) begin
                    csum  <= csum ^ shreg[DATA_WIDTH-1 -: 8];
                    shreg <= shreg << 8;
                    idx   <= idx + 1'b1;
                    state <= idx == LAST ? CSUM : DATA;
                end
                CSUM: if (accept) begin
                    frame_cnt_o <= frame_cnt_o + 1'b1;
                    if (fifo_pop_o) begin
                        shreg <= fifo_data_i;
                        csum  <= '0;
                        idx   <= '0;
                        state <= HDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ts_frame_serializer.sv
// tb_ts_frame_serializer: frame-queue model of the serializer checked every cycle, plus literal
// expectations for the documented scenarios.
module tb_ts_frame_serializer;
    logic        clk = 0, rst_ni = 0, flush_i = 0, fifo_empty_i = 1, tx_ready_i = 0;
    logic [63:0] fifo_data_i = 64'h0;
    logic        pop, txv, busy, pop2, txv2, busy2, pop3, txv3, busy3;
    logic [7:0]  txd, txd2, txd3;
    logic [15:0] cnt, cnt3;
    logic [1:0]  cnt2;
    logic        empty3 = 1, ready3 = 1;
    logic [7:0]  data3 = 8'h00;

    ts_frame_serializer dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .fifo_empty_i(fifo_empty_i),
        .fifo_data_i(fifo_data_i), .fifo_pop_o(pop), .tx_data_o(txd), .tx_valid_o(txv),
        .tx_ready_i(tx_ready_i), .busy_o(busy), .frame_cnt_o(cnt));
    ts_frame_serializer #(.CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .fifo_empty_i(fifo_empty_i),
        .fifo_data_i(fifo_data_i), .fifo_pop_o(pop2), .tx_data_o(txd2), .tx_valid_o(txv2),
        .tx_ready_i(tx_ready_i), .busy_o(busy2), .frame_cnt_o(cnt2));
    ts_frame_serializer #(.DATA_WIDTH(8)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .fifo_empty_i(empty3),
        .fifo_data_i(data3), .fifo_pop_o(pop3), .tx_data_o(txd3), .tx_valid_o(txv3),
        .tx_ready_i(ready3), .busy_o(busy3), .frame_cnt_o(cnt3));

    always #5 clk = ~clk;

    int          tests = 0, fails = 0, mcnt = 0, cyc = 0, mark = 0;
    logic [63:0] fq[$];
    logic [7:0]  exq[$];
    logic        tv_t[1024], tp_t[1024], tb_t[1024], tr_t[1024];
    logic [7:0]  td_t[1024];
    logic [1:0]  tc2_t[1024];
    logic [7:0]  f1[10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    logic [1:0]  wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0]  e3[3] = '{8'hA5, 8'h5A, 8'h5A};
    localparam logic [63:0] W1 = 64'h0102030405060708, W2 = 64'hFFFFFFFFFFFFFFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [63:0] w);
        logic [7:0] c = 8'h00;
        exq.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            exq.push_back(w[i*8 +: 8]);
            c ^= w[i*8 +: 8];
        end
        exq.push_back(c);
    endfunction

    // one clock cycle, entered and left at a falling edge
    task automatic cycle(input logic rdy, input logic fl);
        logic ev, ep;
        logic [7:0] ed;
        tx_ready_i = rdy;
        flush_i = fl;
        fifo_empty_i = fq.size() == 0;
        fifo_data_i = fifo_empty_i ? 64'h0 : fq[0];
        #1;
        ev = exq.size() > 0;
        ed = ev ? exq[0] : 8'h00;
        ep = !fl && fq.size() > 0 && (!ev || (exq.size() == 1 && rdy));
        chk("tx_valid", txv, ev);
        chk("tx_data", txd, ed);
        chk("busy", busy, ev);
        chk("fifo_pop", pop, ep);
        chk("frame_cnt", cnt, mcnt[15:0]);
        chk("frame_cnt_w2", cnt2, mcnt[1:0]);
        chk("tx_data_w2", txd2, ed);
        tv_t[cyc] = txv; td_t[cyc] = txd; tp_t[cyc] = pop; tb_t[cyc] = busy;
        tc2_t[cyc] = cnt2; tr_t[cyc] = rdy;
        cyc++;
        @(posedge clk);
        if (fl) exq.delete();
        else begin
            if (ev && rdy) begin
                void'(exq.pop_front());
                if (exq.size() == 0) mcnt++;
            end
            if (ep) push_frame(fq[0]);
        end
        if (ep) void'(fq.pop_front());
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [1:0] seen[$];
        logic [7:0] acc[$];
        #3;
        chk("rst_valid", txv, 0); chk("rst_data", txd, 0); chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0); chk("rst_pop", pop, 0);
        @(negedge clk);
        rst_ni = 1;
        // empty FIFO
        mark = cyc;
        for (int i = 0; i < 50; i++) cycle(1, 0);
        n = 0;
        for (int i = mark; i < cyc; i++) n += int'(tv_t[i]) + int'(tp_t[i]);
        chk("empty_activity", n, 0);
        // single frame
        fq.push_back(W1);
        mark = cyc;
        for (int i = 0; i < 12; i++) cycle(1, 0);
        chk("single_pop0", tp_t[mark], 1);
        for (int i = 0; i < 10; i++) begin
            chk("single_valid", tv_t[mark+1+i], 1);
            chk("single_byte", td_t[mark+1+i], f1[i]);
        end
        chk("single_busy_end", tb_t[mark+11], 0);
        chk("single_cnt", cnt, 1);
        // back-to-back
        fq.push_back(W1); fq.push_back(W2);
        mark = cyc;
        for (int i = 0; i < 21; i++) cycle(1, 0);
        n = 0;
        for (int i = 1; i <= 20; i++) n += int'(tv_t[mark+i]);
        chk("b2b_valid_run", n, 20);
        chk("b2b_pop0", tp_t[mark], 1);
        chk("b2b_pop10", tp_t[mark+10], 1);
        chk("b2b_sof2", td_t[mark+11], 8'hA5);
        chk("b2b_ff", td_t[mark+15], 8'hFF);
        chk("b2b_csum2", td_t[mark+20], 8'h00);
        chk("b2b_cnt", cnt, 3);
        // backpressure on the third byte
        fq.push_back(W1);
        mark = cyc;
        for (int i = 0; i < 20; i++) cycle((i >= 3 && i < 8) ? 1'b0 : 1'b1, 0);
        for (int i = 3; i < 8; i++) begin
            chk("bp_hold_data", td_t[mark+i], 8'h02);
            chk("bp_hold_valid", tv_t[mark+i], 1);
        end
        for (int i = mark; i < cyc; i++) if (tv_t[i] && tr_t[i]) acc.push_back(td_t[i]);
        chk("bp_count", acc.size(), 10);
        for (int i = 0; i < 10 && i < acc.size(); i++) chk("bp_stream", acc[i], f1[i]);
        chk("bp_cnt", cnt, 4);
        // flush on the 4th payload byte, next word restarts cleanly
        fq.push_back(W1); fq.push_back(W2);
        mark = cyc;
        for (int i = 0; i < 20; i++) cycle(1, i == 5);
        chk("flush_byte", td_t[mark+5], 8'h04);
        chk("flush_nopop", tp_t[mark+5], 0);
        chk("flush_valid_next", tv_t[mark+6], 0);
        chk("flush_pop_after", tp_t[mark+6], 1);
        chk("flush_restart", td_t[mark+7], 8'hA5);
        chk("flush_cnt", cnt, 5);
        // async reset mid-DATA with a word still waiting
        fq.push_back(W1); fq.push_back(W2);
        for (int i = 0; i < 4; i++) cycle(1, 0);
        #2;
        rst_ni = 0;
        #1;
        chk("arst_valid", txv, 0); chk("arst_data", txd, 0); chk("arst_busy", busy, 0);
        chk("arst_cnt", cnt, 0); chk("arst_pop", pop, 0);
        exq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        chk("arst_hold_valid", txv, 0); chk("arst_hold_pop", pop, 0);
        @(negedge clk);
        rst_ni = 1;
        // five frames on the 2-bit counter
        for (int i = 0; i < 4; i++) fq.push_back(64'h1111111111111111 * (i + 1));
        mark = cyc;
        for (int i = 0; i < 60; i++) cycle(1, 0);
        for (int i = mark + 1; i < cyc; i++) if (tc2_t[i] != tc2_t[i-1]) seen.push_back(tc2_t[i]);
        chk("wrap_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("wrap_seq", seen[i], wrap_exp[i]);
        // single-byte payload
        empty3 = 0;
        data3 = 8'h5A;
        #1;
        chk("n1_pop", pop3, 1);
        @(negedge clk);
        empty3 = 1;
        for (int i = 0; i < 3; i++) begin
            chk("n1_valid", txv3, 1);
            chk("n1_byte", txd3, e3[i]);
            @(negedge clk);
        end
        chk("n1_idle", txv3, 0);
        chk("n1_cnt", cnt3, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ts_frame_serializer.md
Name: ts_frame_serializer

Overview:
Downstream consumer of the timestamp FIFO. It pops one DATA_WIDTH-bit word at a time and emits it as a byte-wide framed stream over a valid/ready interface. Frame format: SOF byte, then the payload MSB-first, then an XOR checksum byte. The serializer output feeds the link/UART transmitter of the time distribution link.

Parameters:
DATA_WIDTH, 64, FIFO word width; must be a multiple of 8 and at least 8 (N = DATA_WIDTH/8 payload bytes).
SOF_BYTE, 8'hA5, start-of-frame marker byte.
CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active-low
flush_i  input  1  synchronous abort: drop the current frame and return to IDLE
fifo_empty_i  input  1  FIFO empty flag
fifo_data_i  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_i=0
fifo_pop_o  output  1  pop strobe to the FIFO, one cycle per word
tx_data_o  output  8  output byte
tx_valid_o  output  1  tx_data_o is valid
tx_ready_i  input  1  sink accepts the byte
busy_o  output  1  a frame is in progress (state != IDLE)
frame_cnt_o  output  CNT_WIDTH  number of completed frames, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_ni=0, async): state=IDLE. fifo_pop_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, frame_cnt_o=0. Shift register, byte index and checksum all cleared.
- Byte transfer occurs on a clock edge where tx_valid_o && tx_ready_i ("accept").
- FSM states: IDLE, HDR, DATA, CSUM.
- IDLE:
  - fifo_pop_o = !fifo_empty_i (combinational).
  - On pop, latch fifo_data_i into the shift register, clear the checksum, set byte index=0, go to HDR.
  - Latency: FIFO non-empty at cycle 0 -> pop at cycle 0 -> tx_valid_o=1 with SOF_BYTE at cycle 1.
- HDR: tx_data_o=SOF_BYTE, tx_valid_o=1. On accept, go to DATA.
- DATA:
  - tx_data_o = shift register [DATA_WIDTH-1 -: 8], tx_valid_o=1.
  - On accept: checksum ^= tx_data_o, shift left by 8, index++.
  - After accepting byte N-1, go to CSUM.
- CSUM:
  - tx_data_o = checksum (XOR of the N payload bytes only; SOF excluded), tx_valid_o=1.
  - On accept: frame_cnt_o++.
  - If fifo_empty_i=0 on that same cycle: assert fifo_pop_o, latch the next word, go to HDR (zero-bubble back-to-back frames).
  - Otherwise go to IDLE.
- fifo_pop_o is asserted only in IDLE, or in CSUM on accept; it is never asserted when fifo_empty_i=1.
- Handshake stability: while tx_valid_o=1 and tx_ready_i=0, tx_data_o and the state hold. tx_valid_o never drops without an accept, except on flush_i or reset.
- tx_ready_i may be high while tx_valid_o=0; this has no effect.
- flush_i=1 (synchronous):
  - Next state=IDLE, tx_valid_o=0 the next cycle; the partial frame is abandoned and frame_cnt_o is unchanged.
  - fifo_pop_o is forced to 0 during a flush cycle.
  - flush_i has priority over an accept in the same cycle.
- Reset mid-frame: immediate return to the reset values; no pop is issued.
- busy_o = (state != IDLE), registered with the state.
- frame_cnt_o wraps from 2^CNT_WIDTH-1 to 0 silently.
- Byte index width = clog2(N), minimum 1. N=1 is legal: the frame is SOF, one byte, checksum equal to that byte.

Test Plan:
- Single frame: DATA_WIDTH=64, push 0x0102030405060708, tx_ready_i=1 -> pop at cycle 0; bytes A5,01,02,03,04,05,06,07,08,08 on cycles 1-10; frame_cnt_o=1; busy_o=0 at cycle 11.
- Back-to-back: two words queued (0x0102030405060708, then 0xFFFFFFFFFFFFFFFF), tx_ready_i=1 -> 20 consecutive valid cycles with no bubble; second frame is A5, eight FF, checksum 00; pop pulses at cycles 0 and 10; frame_cnt_o=2.
- Backpressure: tx_ready_i=0 for 5 cycles while the 3rd byte (0x02) is presented -> tx_data_o held at 0x02 and tx_valid_o held 1 throughout; the resulting stream is identical to the single-frame case.
- Flush mid-frame: assert flush_i during the 4th DATA byte -> tx_valid_o=0 next cycle, state IDLE, frame_cnt_o unchanged, no pop during the flush cycle. The next queued word then starts cleanly with A5.
- Empty FIFO: fifo_empty_i=1 for 50 cycles -> fifo_pop_o=0 and tx_valid_o=0 throughout. Async reset asserted mid-DATA -> all outputs at 0 immediately.
- Counter wrap: CNT_WIDTH=2, send 5 frames -> frame_cnt_o sequence 1,2,3,0,1.
